ppl_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline; sits directly upstream of the IF/ID register.
- Owns the architectural fetch PC and runs a req/ack handshake to instruction memory (variable wait states).
- Absorbs decode stalls and branch/jump redirects.
- Drives the IF/ID register's pcIn, instIn and pcContinue (write enable).

---
 rtl/ppl_pkg.sv | 27 ++
 rtl/ppl_fetch_if.sv | 33 +++
 rtl/ppl_sat_counter.sv | 27 ++
 rtl/ppl_fetch.sv | 173 +++++++++++++++++
 tb/tb_ppl_fetch.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppl_pkg.sv
// ---------------------------------------------------------------------------
// ppl_pkg -- shared definitions for the pipeline front end.
//
// Contents:
//   fetch_state_e  fetch FSM states (S_IDLE, S_REQ, S_HOLD, S_DRAIN)
//   RESET_PC       default PC loaded on reset
//   NOP_INST       instruction word used for pipeline bubbles
//   align_word()   clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package ppl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,  // first cycle after reset release, no request yet
        S_REQ   = 2'd1,  // request outstanding for the current PC
        S_HOLD  = 2'd2,  // fetched word parked while decode is stalled
        S_DRAIN = 2'd3   // waiting out a request whose data will be dropped
    } fetch_state_e;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Misaligned targets are silently truncated to the enclosing word.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ppl_fetch_if.sv
// ---------------------------------------------------------------------------
// ppl_fetch_if -- instruction-memory request/ack bus.
//
// Signals:
//   imemReq    fetch request valid (fetch -> memory)
//   imemAddr   word-aligned fetch address (fetch -> memory)
//   imemAck    imemRdata valid this cycle (memory -> fetch)
//   imemRdata  fetched instruction word (memory -> fetch)
//
// Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface ppl_fetch_if;

    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemAck,
        input  imemRdata
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemAck,
        output imemRdata
    );

endinterface

// File: rtl/ppl_sat_counter.sv
// ---------------------------------------------------------------------------
// ppl_sat_counter -- event counter that sticks at all-ones.
//
// Ports:
//   clk    clock, posedge
//   reset  asynchronous, active-low reset (clears the count)
//   en     count one event this cycle
//   count  current count, saturating at 2^WIDTH-1
// ---------------------------------------------------------------------------
module ppl_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ppl_fetch.sv
// ---------------------------------------------------------------------------
// ppl_fetch -- instruction-fetch stage feeding the IF/ID register.
//
// Owns the fetch PC, runs a req/ack handshake with instruction memory
// (any number of wait states), and absorbs decode stalls and redirects.
// pcOut/instOut/pcContinue are combinational so the IF/ID register can
// capture an acknowledged word on the same edge it arrives.
//
// Ports:
//   clk         clock, posedge
//   reset       asynchronous, active-low reset
//   stall       IF/ID must hold this cycle
//   redirect    taken branch/jump/exception; current fetch is discarded
//   redirectPc  redirect target (low two bits ignored)
//   imem        instruction-memory bus (ppl_fetch_if.master)
//   pcOut       PC of delivered instruction  (IF/ID pcIn)
//   instOut     delivered instruction, 0 for a bubble (IF/ID instIn)
//   pcContinue  IF/ID write enable
//
// Optional feature, enabled by defining FETCH_PERF_EN:
//   perfWaitCnt    cycles spent with a request waiting for ack (saturating)
//   perfBubbleCnt  redirect bubbles written into IF/ID (saturating)
// ---------------------------------------------------------------------------
module ppl_fetch #(
    parameter logic [31:0] RESET_PC = ppl_pkg::RESET_PC,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    ppl_fetch_if.master imem,
    output logic [31:0] pcOut,
    output logic [31:0] instOut,
    output logic        pcContinue
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perfWaitCnt,
    output logic [31:0] perfBubbleCnt
`endif
);

    import ppl_pkg::*;

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  hold_inst, hold_inst_n;
    logic [31:0]  pend_pc, pend_pc_n;
    logic [31:0]  redirect_target;

    assign redirect_target = align_word(redirectPc);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values computed for this cycle, not a
    // partially updated mix.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            hold_inst <= NOP_INST;
            pend_pc   <= RESET_PC;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            hold_inst <= hold_inst_n;
            pend_pc   <= pend_pc_n;
        end
    end

    // Priority inside every state: redirect > stall > normal progress.
    always_comb begin
        // NOTE: every output and next-state value gets a default before the
        // case statement, so no path through the logic can infer a latch.
        state_n       = state;
        pc_n          = pc;
        hold_inst_n   = hold_inst;
        pend_pc_n     = pend_pc;
        imem.imemReq  = 1'b0;
        imem.imemAddr = pc;
        pcOut         = pc;
        instOut       = NOP_INST;
        pcContinue    = 1'b0;

        case (state)
            S_IDLE: begin
                state_n = S_REQ;
                if (redirect) begin
                    pc_n = redirect_target;
                end
            end

            S_REQ: begin
                imem.imemReq = 1'b1;
                if (redirect) begin
                    // Bubble into IF/ID unless decode is holding it.
                    pcContinue = ~stall;
                    if (imem.imemAck) begin
                        pc_n = redirect_target;
                    end else begin
                        // The bus cannot retract the request: finish it first.
                        pend_pc_n = redirect_target;
                        state_n   = S_DRAIN;
                    end
                end else if (imem.imemAck) begin
                    if (stall) begin
                        hold_inst_n = imem.imemRdata;
                        state_n     = S_HOLD;
                    end else begin
                        pcContinue = 1'b1;
                        instOut    = imem.imemRdata;
                        pc_n       = pc + PC_STEP;
                    end
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pcContinue = ~stall;
                    pc_n       = redirect_target;
                    state_n    = S_REQ;
                end else begin
                    instOut = hold_inst;
                    if (!stall) begin
                        pcContinue = 1'b1;
                        pc_n       = pc + PC_STEP;
                        state_n    = S_REQ;
                    end
                end
            end

            S_DRAIN: begin
                // Address stays on the old PC; pend_pc carries the target.
                imem.imemReq = 1'b1;
                if (redirect) begin
                    pend_pc_n = redirect_target;
                end
                if (imem.imemAck) begin
                    pc_n    = redirect ? redirect_target : pend_pc;
                    state_n = S_REQ;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

`ifdef FETCH_PERF_EN
    logic wait_evt;
    logic bubble_evt;

    assign wait_evt   = imem.imemReq && !imem.imemAck;
    // A bubble only counts when it is actually written into IF/ID.
    assign bubble_evt = redirect && !stall && ((state == S_REQ) || (state == S_HOLD));

    ppl_sat_counter #(.WIDTH(32)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (wait_evt),
        .count (perfWaitCnt)
    );

    ppl_sat_counter #(.WIDTH(32)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (bubble_evt),
        .count (perfBubbleCnt)
    );
`endif

endmodule

// File: tb/tb_ppl_fetch.sv
// ---------------------------------------------------------------------------
// tb_ppl_fetch -- self-checking bench for ppl_fetch.
//
// A driver process chooses the inputs for each cycle, plays instruction
// memory, and advances a transaction-level model of the fetch stage. The
// model pushes the expected bus activity and the expected IF/ID deliveries
// into queues; a monitor on the falling edge pops and compares them against
// the DUT. Build with FETCH_PERF_EN defined to also check the counters.
// ---------------------------------------------------------------------------
module tb_ppl_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = '0;
    logic [31:0] pcOut;
    logic [31:0] instOut;
    logic        pcContinue;
`ifdef FETCH_PERF_EN
    logic [31:0] perfWaitCnt;
    logic [31:0] perfBubbleCnt;
`endif

    ppl_fetch_if imem_bus ();

    ppl_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .imem       (imem_bus),
        .pcOut      (pcOut),
        .instOut    (instOut),
        .pcContinue (pcContinue)
`ifdef FETCH_PERF_EN
        ,
        .perfWaitCnt   (perfWaitCnt),
        .perfBubbleCnt (perfBubbleCnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        bit          req;
        logic [31:0] addr;
    } bus_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] inst;
    } dlv_t;

    bus_t bus_q[$];
    dlv_t dlv_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural view: m_pc is the next instruction the pipeline wants,
    // m_held holds a word fetched while decode was stalled, and m_discard
    // marks a bus transaction (to m_stale) whose data nobody wants.
    bit          m_started;
    bit          m_discard;
    logic [31:0] m_pc;
    logic [31:0] m_stale;
    logic [31:0] m_held[$];
    int          m_wait;
    int          m_bubble;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_A5A5;
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_discard = 1'b0;
        m_pc      = RST_PC;
        m_stale   = RST_PC;
        m_held.delete();
        m_wait    = 0;
        m_bubble  = 0;
        bus_q.delete();
        dlv_q.delete();
    endtask

    task automatic expect_delivery(input logic [31:0] pc, input logic [31:0] inst);
        dlv_t d;
        d.cyc  = cyc;
        d.pc   = pc;
        d.inst = inst;
        dlv_q.push_back(d);
    endtask

    // Called at posedge+1: applies this cycle's inputs, records what the
    // stage must do this cycle, then waits for the next posedge+1.
    task automatic drive_cycle(input bit st, input bit rd, input logic [31:0] tgt, input int ack_pct);
        bit          req;
        bit          ack;
        logic [31:0] addr;
        logic [31:0] tgt_a;
        bus_t        b;

        cyc++;
        req   = m_started && (m_held.size() == 0);
        addr  = m_discard ? m_stale : m_pc;
        ack   = ($urandom_range(99) < ack_pct);
        tgt_a = tgt & 32'hFFFF_FFFC;

        stall              = st;
        redirect           = rd;
        redirectPc         = tgt;
        imem_bus.imemAck   = ack;
        imem_bus.imemRdata = (req && ack) ? mem_word(addr) : $urandom();

        b.req  = req;
        b.addr = addr;
        bus_q.push_back(b);
        if (req && !ack) m_wait++;

        if (!m_started) begin
            m_started = 1'b1;
            if (rd) m_pc = tgt_a;
        end else if (m_discard) begin
            if (rd) m_pc = tgt_a;
            if (ack) m_discard = 1'b0;
        end else if (rd) begin
            if (!st) begin
                expect_delivery(m_pc, 32'h0);
                m_bubble++;
            end
            if (m_held.size() != 0) begin
                m_held.delete();
            end else if (!ack) begin
                m_stale   = m_pc;
                m_discard = 1'b1;
            end
            m_pc = tgt_a;
        end else if (m_held.size() != 0) begin
            if (!st) begin
                expect_delivery(m_pc, m_held.pop_front());
                m_pc = m_pc + 32'd4;
            end
        end else if (ack) begin
            if (st) begin
                m_held.push_back(mem_word(m_pc));
            end else begin
                expect_delivery(m_pc, mem_word(m_pc));
                m_pc = m_pc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        bus_t b;
        dlv_t d;
        if (mon_en) begin
            if (bus_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_expectation_missing: cycle %0d has no expected bus entry", cyc);
            end else begin
                b = bus_q.pop_front();
                check("imemReq", imem_bus.imemReq, b.req);
                if (b.req) check("imemAddr", imem_bus.imemAddr, b.addr);
            end
            check("continue_while_stall", pcContinue && stall, 1'b0);
            if (pcContinue) begin
                if (dlv_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_delivery: pcOut=%h instOut=%h, none expected (cycle %0d)",
                             pcOut, instOut, cyc);
                end else begin
                    d = dlv_q.pop_front();
                    check("delivery_cycle", cyc, d.cyc);
                    check("pcOut", pcOut, d.pc);
                    check("instOut", instOut, d.inst);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        imem_bus.imemAck   = 1'b0;
        imem_bus.imemRdata = '0;
        model_reset();

        // Reset state.
        #12;
        check("rst_imemReq", imem_bus.imemReq, 1'b0);
        check("rst_imemAddr", imem_bus.imemAddr, RST_PC);
        check("rst_pcOut", pcOut, RST_PC);
        check("rst_instOut", instOut, 32'h0);
        check("rst_pcContinue", pcContinue, 1'b0);
`ifdef FETCH_PERF_EN
        check("rst_perfWait", perfWaitCnt, 32'h0);
        check("rst_perfBubble", perfBubbleCnt, 32'h0);
`endif

        // Release reset just after an edge so the idle cycle is a full cycle.
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        // Directed walk through the documented scenarios.
        drive_cycle(0, 0, 32'h0, 100);          // idle cycle
        drive_cycle(0, 0, 32'h0, 100);          // 8000_0000 delivered
        repeat (3) drive_cycle(0, 0, 32'h0, 0); // three wait states at 8000_0004
        drive_cycle(0, 0, 32'h0, 100);          // 8000_0004 delivered
        drive_cycle(1, 0, 32'h0, 100);          // ack at 8000_0008 under stall
        drive_cycle(1, 0, 32'h0, 0);            // still holding
        drive_cycle(0, 0, 32'h0, 0);            // held word delivered
        drive_cycle(0, 1, 32'h8000_0103, 0);    // redirect while waiting: bubble
        repeat (2) drive_cycle(0, 0, 32'h0, 0); // drain keeps old address
        drive_cycle(0, 0, 32'h0, 100);          // drained data dropped
        drive_cycle(0, 0, 32'h0, 100);          // 8000_0100 delivered
        drive_cycle(1, 1, 32'h8000_0200, 100);  // redirect + stall: no bubble
        drive_cycle(0, 0, 32'h0, 100);          // 8000_0200 delivered
        drive_cycle(0, 1, 32'hFFFF_FFFE, 100);  // redirect near the top of memory
        drive_cycle(0, 0, 32'h0, 100);          // FFFF_FFFC delivered
        drive_cycle(0, 0, 32'h0, 100);          // PC wraps to 0000_0000
        drive_cycle(1, 0, 32'h0, 100);          // park 0000_0004
        drive_cycle(0, 1, 32'h8000_0300, 0);    // redirect out of hold
        drive_cycle(0, 1, 32'h8000_0400, 0);    // redirect while waiting
        drive_cycle(0, 1, 32'h8000_0500, 0);    // re-redirect during drain
        drive_cycle(0, 1, 32'h8000_0600, 100);  // ack + redirect in drain
        drive_cycle(0, 0, 32'h0, 100);          // 8000_0600 delivered
        drive_cycle(0, 1, 32'h8000_0700, 0);    // enter drain again
        drive_cycle(0, 0, 32'h0, 0);            // still draining

        // Reset in the middle of a drain.
        mon_en = 1'b0;
        check("dir_deliveries_done", dlv_q.size(), 32'd0);
`ifdef FETCH_PERF_EN
        check("dir_perfWait", perfWaitCnt, m_wait);
        check("dir_perfBubble", perfBubbleCnt, m_bubble);
`endif
        #2;
        reset = 1'b0;
        #1;
        check("drain_rst_imemReq", imem_bus.imemReq, 1'b0);
        check("drain_rst_pcOut", pcOut, RST_PC);
        check("drain_rst_instOut", instOut, 32'h0);
        check("drain_rst_pcContinue", pcContinue, 1'b0);
`ifdef FETCH_PERF_EN
        check("drain_rst_perfWait", perfWaitCnt, 32'h0);
        check("drain_rst_perfBubble", perfBubbleCnt, 32'h0);
`endif

        // Randomized traffic.
        @(posedge clk);
        #1;
        model_reset();
        reset  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            else                        tgt = RST_PC + 32'($urandom_range(4095));
            drive_cycle($urandom_range(99) < 30, $urandom_range(99) < 12, tgt, 55);
        end

        mon_en = 1'b0;
        check("rand_deliveries_done", dlv_q.size(), 32'd0);
`ifdef FETCH_PERF_EN
        check("rand_perfWait", perfWaitCnt, m_wait);
        check("rand_perfBubble", perfBubbleCnt, m_bubble);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
